// File: rtl/rr_sel_sequencer_if.sv
// Select/grant bundle between a request source and the round-robin mux sequencer.
// The sequencer side uses the slave modport; requesters/observers use master.
interface rr_sel_sequencer_if;
  logic       en;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;

  modport master (output en, req, input sel, gnt, valid);
  modport slave  (input en, req, output sel, gnt, valid);
endinterface

// File: rtl/rr_sel_sequencer.sv
// Round-robin arbiter producing the 2-bit sel of a 4:1 mux, with a bounded hold
// window per grant and a mandatory idle cycle between grants.
//
// state | meaning
// IDLE  | no grant; search from last+1 when en and any req
// GRANT | sel/gnt held until requester drops or hold counter hits zero
module rr_sel_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_sel_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_last, w_last_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic [3:0]    r_gnt, w_gnt_nxt;
  logic          r_valid, w_valid_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    w_win, w_idx;
  logic          w_found;

  // Rotating priority: first asserted channel at or after last+1.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
        if (bus.en && w_found) begin
          w_sel_nxt   = w_win;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = HOLD_INIT;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // en is deliberately not consulted here: a running grant always completes.
        if (!bus.req[r_sel] || (r_cnt == '0)) begin
          w_last_nxt  = r_sel;
          w_gnt_nxt   = 4'b0000;
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 2'b11;
      r_sel   <= 2'b00;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.sel   = r_sel;
  assign bus.gnt   = r_gnt;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Bench for rr_sel_sequencer: two instances (hold 4 and hold 1) share stimulus;
// a reference model pushes expected outputs per cycle, popped after each edge.
module tb_rr_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;

  always #5 clk = ~clk;

  rr_sel_sequencer_if if_a ();
  rr_sel_sequencer_if if_b ();

  assign if_a.en  = en;
  assign if_a.req = req;
  assign if_b.en  = en;
  assign if_b.req = req;

  rr_sel_sequencer #(.HOLD_CYCLES(4), .CW(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  rr_sel_sequencer #(.HOLD_CYCLES(1), .CW(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
  } exp_t;

  exp_t q_exp[$];

  int n_checks = 0;
  int n_pass   = 0;

  int         m_state [2];
  int         m_last  [2];
  int         m_cnt   [2];
  int         m_sel   [2];
  logic [3:0] m_gnt   [2];
  logic       m_valid [2];
  int         m_hold  [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_last[d]  = 3;
      m_cnt[d]   = 0;
      m_sel[d]   = 0;
      m_gnt[d]   = 4'b0000;
      m_valid[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d);
    int c;
    bit found;
    if (m_state[d] == 0) begin
      m_gnt[d]   = 4'b0000;
      m_valid[d] = 1'b0;
      if (en && req != 4'b0000) begin
        found = 0;
        for (int i = 1; i <= 4; i++) begin
          c = (m_last[d] + i) % 4;
          if (!found && req[c]) begin
            found      = 1;
            m_sel[d]   = c;
            m_gnt[d]   = 4'(1 << c);
            m_valid[d] = 1'b1;
            m_cnt[d]   = m_hold[d] - 1;
            m_state[d] = 1;
          end
        end
      end
    end else begin
      if (!req[m_sel[d]] || m_cnt[d] == 0) begin
        m_last[d]  = m_sel[d];
        m_gnt[d]   = 4'b0000;
        m_valid[d] = 1'b0;
        m_state[d] = 0;
      end else begin
        m_cnt[d] = m_cnt[d] - 1;
      end
    end
  endtask

  task automatic cmp_dut(input int d, input logic [1:0] s, input logic [3:0] g, input logic v);
    exp_t e;
    e = q_exp.pop_front();
    check($sformatf("dut%0d_sel", d), {6'd0, s}, {6'd0, e.sel});
    check($sformatf("dut%0d_gnt", d), {4'd0, g}, {4'd0, e.gnt});
    check($sformatf("dut%0d_valid", d), {7'd0, v}, {7'd0, e.valid});
    check($sformatf("dut%0d_valid_eq_or_gnt", d), {7'd0, v}, {7'd0, |g});
  endtask

  // One clock: model predicts, DUT advances, predictions are popped and compared.
  task automatic cycle();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      model_edge(d);
      e.sel   = 2'(m_sel[d]);
      e.gnt   = m_gnt[d];
      e.valid = m_valid[d];
      q_exp.push_back(e);
    end
    @(posedge clk);
    #1;
    cmp_dut(0, if_a.sel, if_a.gnt, if_a.valid);
    cmp_dut(1, if_b.sel, if_b.gnt, if_b.valid);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_sel_a",   {6'd0, if_a.sel},   8'h00);
    check("rst_gnt_a",   {4'd0, if_a.gnt},   8'h00);
    check("rst_valid_a", {7'd0, if_a.valid}, 8'h00);
    check("rst_valid_b", {7'd0, if_b.valid}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int         rot_sel[$];
  int         rot_len[$];
  int         exp_rot[5];
  logic       exp_vb[4];
  int         cur_len;
  logic       prev_v;
  int         vcount;

  initial begin
    m_hold[0] = 4;
    m_hold[1] = 1;
    exp_rot   = '{0, 1, 2, 3, 0};
    exp_vb    = '{1'b1, 1'b0, 1'b1, 1'b0};
    en    = 1'b0;
    req   = 4'b0000;
    rst_n = 1'b1;
    #1;
    do_reset();

    // en low with a pending request: no grant ever starts
    en = 1'b0; req = 4'b0010;
    for (int i = 0; i < 6; i++) cycle();
    check("en_low_no_grant", {7'd0, if_a.valid}, 8'h00);

    // rotation with all requesting
    en = 1'b1; req = 4'b1111;
    prev_v = 1'b0; cur_len = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (if_a.valid && !prev_v) rot_sel.push_back(int'(if_a.sel));
      if (if_a.valid) cur_len++;
      else if (prev_v) begin rot_len.push_back(cur_len); cur_len = 0; end
      prev_v = if_a.valid;
    end
    check("rot_count", 8'(rot_sel.size()), 8'd5);
    for (int i = 0; i < 5 && i < rot_sel.size(); i++)
      check($sformatf("rot_sel%0d", i), 8'(rot_sel[i]), 8'(exp_rot[i]));
    for (int i = 0; i < rot_len.size(); i++)
      check($sformatf("rot_len%0d", i), 8'(rot_len[i]), 8'd4);

    req = 4'b0000;
    for (int i = 0; i < 2; i++) cycle();

    // skip and wrap: last=1, then req 1001 -> 3 then 0
    req = 4'b0010;
    for (int i = 0; i < 5; i++) cycle();
    req = 4'b1001;
    cycle();
    check("wrap_sel3", {6'd0, if_a.sel}, 8'd3);
    check("wrap_gnt3", {4'd0, if_a.gnt}, 8'h08);
    for (int i = 0; i < 5; i++) cycle();
    check("wrap_sel0",   {6'd0, if_a.sel},   8'd0);
    check("wrap_valid0", {7'd0, if_a.valid}, 8'd1);
    for (int i = 0; i < 4; i++) cycle();

    // early release of channel 2
    req = 4'b0100;
    for (int i = 0; i < 2; i++) cycle();
    req = 4'b0000;
    cycle();
    check("early_release_valid", {7'd0, if_a.valid}, 8'd0);
    req = 4'b0100;
    cycle();
    check("regrant_sel2", {6'd0, if_a.sel}, 8'd2);
    check("regrant_valid", {7'd0, if_a.valid}, 8'd1);
    for (int i = 0; i < 4; i++) cycle();

    // en dropped during a channel 1 grant: grant completes, nothing follows
    req = 4'b0010;
    cycle();
    vcount = int'(if_a.valid);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      vcount += int'(if_a.valid);
    end
    check("en_drop_grant_len", 8'(vcount), 8'd4);
    check("en_drop_no_regrant", {7'd0, if_a.valid}, 8'd0);

    // hold of 1: alternating single-cycle grants on instance b
    en = 1'b0; req = 4'b0000;
    do_reset();
    en = 1'b1; req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("h1_valid%0d", i), {7'd0, if_b.valid}, {7'd0, exp_vb[i]});
      if (exp_vb[i]) check($sformatf("h1_sel%0d", i), {6'd0, if_b.sel}, 8'(i / 2));
    end

    // asynchronous reset in the middle of a channel 2 grant
    en = 1'b0; req = 4'b0000;
    do_reset();
    en = 1'b1; req = 4'b0100;
    for (int i = 0; i < 2; i++) cycle();
    check("pre_rst_valid", {7'd0, if_a.valid}, 8'd1);
    check("pre_rst_sel2",  {6'd0, if_a.sel},   8'd2);
    do_reset();
    req = 4'b1111;
    cycle();
    check("post_rst_sel0",   {6'd0, if_a.sel},   8'd0);
    check("post_rst_valid",  {7'd0, if_a.valid}, 8'd1);

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      req = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
